edge_stream_generator: RTL and testbench

- Per-lane edge generator that expands one vertex task (vtx_id, offset range [off_begin, off_end)) into a stream of HBM edge-list read requests.
- Unpacks returned beats into EDGES_PER_BEAT destination IDs per cycle with a slot-valid mask.
- Sits between the offset-lookup stage and the edge pipelines; one instance per HBM channel.
- Adds valid/ready backpressure, credit-bounded outstanding reads and exact range masking.

---
 rtl/edge_stream_generator.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_edge_stream_generator.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_stream_generator.sv
// ---------------------------------------------------------------------------
// edge_stream_generator
//
// Per-HBM-channel edge generator. It takes one vertex task (source vertex plus
// a CSR offset range [off_begin, off_end)) and turns it into a stream of HBM
// beat read requests. Returned beats are unpacked into EDGES_PER_BEAT
// destination IDs per cycle, with a per-slot valid mask that trims the
// partial first and last beats of the range.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   task_vtx_id       source vertex of the offered task
//   task_off_begin    first edge index of the task
//   task_off_end      one past the last edge index of the task
//   task_valid/ready  task handshake
//   rd_addr           HBM read byte address of the current request
//   rd_valid/ready    read request handshake
//   rd_data           returned beat, slot k at [(k+1)*VW-1 : k*VW]
//   rd_data_valid     returned beat strobe (in order, no backpressure)
//   edge_src          source vertex of the beat on the output
//   edge_dst          EDGES_PER_BEAT packed destination IDs
//   edge_mask         per-slot valid
//   edge_valid/ready  output beat handshake
//
// Notes
//   EDGES_PER_BEAT must be a power of two and MAX_OUTSTANDING at least 2.
// ---------------------------------------------------------------------------
module edge_stream_generator #(
  parameter int VERTEX_ID_WIDTH = 32,
  parameter int OFFSET_WIDTH    = 32,
  parameter int HBM_DWIDTH      = 256,
  parameter int ADDR_WIDTH      = 28,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int MAX_OUTSTANDING = 8,
  localparam int EDGES_PER_BEAT = HBM_DWIDTH / VERTEX_ID_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic [VERTEX_ID_WIDTH-1:0] task_vtx_id,
  input  logic [OFFSET_WIDTH-1:0]    task_off_begin,
  input  logic [OFFSET_WIDTH-1:0]    task_off_end,
  input  logic                       task_valid,
  output logic                       task_ready,

  output logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  input  logic [HBM_DWIDTH-1:0]      rd_data,
  input  logic                       rd_data_valid,

  output logic [VERTEX_ID_WIDTH-1:0] edge_src,
  output logic [HBM_DWIDTH-1:0]      edge_dst,
  output logic [EDGES_PER_BEAT-1:0]  edge_mask,
  output logic                       edge_valid,
  input  logic                       edge_ready
);

  localparam int LOG_EPB    = $clog2(EDGES_PER_BEAT);
  localparam int BEAT_BYTES = HBM_DWIDTH / 8;
  localparam int CNT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  // Byte address of beat b. Truncating b to ADDR_WIDTH before the multiply
  // gives the same result modulo 2^ADDR_WIDTH, so the address simply wraps.
  function automatic logic [ADDR_WIDTH-1:0] beat_addr(
    input logic [OFFSET_WIDTH-1:0] b
  );
    return BASE_ADDR + ADDR_WIDTH'(b) * ADDR_WIDTH'(BEAT_BYTES);
  endfunction

  // Slot k of beat b is live iff lo <= b*EPB + k < hi. The largest index
  // tested never exceeds 2^OFFSET_WIDTH-1 because b never passes the beat
  // that holds hi-1, so no extra carry bit is needed.
  function automatic logic [EDGES_PER_BEAT-1:0] beat_mask(
    input logic [OFFSET_WIDTH-1:0] b,
    input logic [OFFSET_WIDTH-1:0] lo,
    input logic [OFFSET_WIDTH-1:0] hi
  );
    logic [EDGES_PER_BEAT-1:0] m;
    logic [OFFSET_WIDTH-1:0]   base;
    logic [OFFSET_WIDTH-1:0]   idx;
    m    = '0;
    base = b << LOG_EPB;
    for (int k = 0; k < EDGES_PER_BEAT; k++) begin
      idx  = base + OFFSET_WIDTH'(k);
      m[k] = (idx >= lo) && (idx < hi);
    end
    return m;
  endfunction

  state_t                     state;

  // Task context, held for the life of one task.
  logic [VERTEX_ID_WIDTH-1:0] vtx_q;
  logic [OFFSET_WIDTH-1:0]    begin_q;
  logic [OFFSET_WIDTH-1:0]    end_q;
  logic [OFFSET_WIDTH-1:0]    b_last_q;

  // Beat indices: next to request, next to load into the output register,
  // and the beat currently offered on the output.
  logic [OFFSET_WIDTH-1:0]    issue_beat;
  logic [OFFSET_WIDTH-1:0]    load_beat;
  logic [OFFSET_WIDTH-1:0]    out_beat;

  logic [CNT_W-1:0]           inflight;
  logic [CNT_W-1:0]           inflight_next;
  logic                       credit_ok;

  logic [HBM_DWIDTH-1:0]      fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           fifo_count;
  logic                       fifo_push;
  logic                       fifo_pop;

  logic                       task_fire;
  logic                       task_empty;
  logic                       task_start;
  logic                       issue_fire;
  logic                       out_fire;
  logic [OFFSET_WIDTH-1:0]    task_b_first;
  logic [OFFSET_WIDTH-1:0]    task_b_last;

  assign task_fire    = task_valid & task_ready;
  assign task_empty   = (task_off_end <= task_off_begin);
  assign task_start   = task_fire & ~task_empty;
  assign issue_fire   = rd_valid & rd_ready;
  assign out_fire     = edge_valid & edge_ready;
  assign task_b_first = task_off_begin >> LOG_EPB;
  assign task_b_last  = (task_off_end - OFFSET_WIDTH'(1)) >> LOG_EPB;

  // A beat holds its credit from request until it leaves on the output
  // handshake, so the FIFO plus the output register can never overfill.
  always_comb begin
    inflight_next = inflight;
    if (issue_fire && !out_fire) begin
      inflight_next = inflight + CNT_W'(1);
    end else if (!issue_fire && out_fire) begin
      inflight_next = inflight - CNT_W'(1);
    end
  end

  assign credit_ok = (inflight_next < MAX_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      inflight <= inflight_next;
    end
  end

  // ---- stage: request FSM ----
  // rd_valid is registered from next-cycle credit availability. Credits only
  // shrink through our own issue, so a raised rd_valid cannot drop before
  // its handshake and rd_addr holds while rd_ready is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      task_ready <= 1'b1;
      rd_valid   <= 1'b0;
      rd_addr    <= '0;
      issue_beat <= '0;
      out_beat   <= '0;
    end else begin
      if (out_fire) begin
        out_beat <= out_beat + OFFSET_WIDTH'(1);
      end
      case (state)
        S_IDLE: begin
          // Empty or malformed ranges are consumed and dropped here.
          if (task_start) begin
            vtx_q      <= task_vtx_id;
            begin_q    <= task_off_begin;
            end_q      <= task_off_end;
            b_last_q   <= task_b_last;
            issue_beat <= task_b_first;
            out_beat   <= task_b_first;
            rd_addr    <= beat_addr(task_b_first);
            rd_valid   <= credit_ok;
            task_ready <= 1'b0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue_fire) begin
            if (issue_beat == b_last_q) begin
              rd_valid <= 1'b0;
              state    <= S_DRAIN;
            end else begin
              issue_beat <= issue_beat + OFFSET_WIDTH'(1);
              rd_addr    <= beat_addr(issue_beat + OFFSET_WIDTH'(1));
              rd_valid   <= credit_ok;
            end
          end else if (!rd_valid) begin
            rd_valid <= credit_ok;
          end
        end
        S_DRAIN: begin
          if (out_fire && (out_beat == b_last_q)) begin
            task_ready <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: begin
          state      <= S_IDLE;
          task_ready <= 1'b1;
          rd_valid   <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage: response FIFO ----
  assign fifo_push = rd_data_valid;
  assign fifo_pop  = (fifo_count != '0) && (!edge_valid || edge_ready);

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr] <= rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (fifo_push && !fifo_pop) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (!fifo_push && fifo_pop) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  // ---- stage: output register ----
  // Loading whenever the register is empty or being consumed keeps one beat
  // per cycle flowing; the mask is attached here using the load-side index.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_valid <= 1'b0;
      edge_src   <= '0;
      edge_dst   <= '0;
      edge_mask  <= '0;
      load_beat  <= '0;
    end else begin
      if (task_start) begin
        load_beat <= task_b_first;
      end
      if (fifo_pop) begin
        edge_valid <= 1'b1;
        edge_src   <= vtx_q;
        edge_dst   <= fifo_mem[rd_ptr];
        edge_mask  <= beat_mask(load_beat, begin_q, end_q);
        load_beat  <= load_beat + OFFSET_WIDTH'(1);
      end else if (out_fire) begin
        edge_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_edge_stream_generator.sv
// ---------------------------------------------------------------------------
// tb_edge_stream_generator
//
// Directed bench for edge_stream_generator with default parameters
// (8 edges per beat, 32-byte beats, BASE_ADDR 0). A responder returns each
// accepted request one cycle later with beat data derived from the address;
// monitors log request addresses and delivered output beats.
// ---------------------------------------------------------------------------
module tb_edge_stream_generator;

  localparam int VW  = 32;
  localparam int OW  = 32;
  localparam int DW  = 256;
  localparam int AW  = 28;
  localparam int EPB = DW / VW;

  typedef struct packed {
    logic [VW-1:0]  src;
    logic [EPB-1:0] mask;
    logic [DW-1:0]  dst;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [VW-1:0] task_vtx_id = '0;
  logic [OW-1:0] task_off_begin = '0;
  logic [OW-1:0] task_off_end = '0;
  logic          task_valid = 1'b0;
  logic          task_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic          rd_ready = 1'b1;
  logic [DW-1:0] rd_data = '0;
  logic          rd_data_valid = 1'b0;
  logic [VW-1:0] edge_src;
  logic [DW-1:0] edge_dst;
  logic [EPB-1:0] edge_mask;
  logic          edge_valid;
  logic          edge_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] req_q[$];
  logic [AW-1:0] req_log[$];
  beat_t         out_q[$];

  always #5 clk = ~clk;

  edge_stream_generator dut (
    .clk           (clk),
    .rst           (rst),
    .task_vtx_id   (task_vtx_id),
    .task_off_begin(task_off_begin),
    .task_off_end  (task_off_end),
    .task_valid    (task_valid),
    .task_ready    (task_ready),
    .rd_addr       (rd_addr),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .edge_src      (edge_src),
    .edge_dst      (edge_dst),
    .edge_mask     (edge_mask),
    .edge_valid    (edge_valid),
    .edge_ready    (edge_ready)
  );

  function automatic logic [DW-1:0] make_beat(input logic [AW-1:0] addr);
    logic [DW-1:0] r;
    int b;
    b = int'(addr) / 32;
    for (int k = 0; k < EPB; k++) begin
      r[k*VW +: VW] = 32'hA000_0000 + 32'(b * EPB + k);
    end
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [DW-1:0] got,
                           input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Handshakes seen mid-cycle complete on the following rising edge.
  always @(negedge clk) begin
    beat_t bt;
    if (!rst) begin
      if (rd_valid && rd_ready) begin
        req_q.push_back(rd_addr);
        req_log.push_back(rd_addr);
      end
      if (edge_valid && edge_ready) begin
        bt.src  = edge_src;
        bt.mask = edge_mask;
        bt.dst  = edge_dst;
        out_q.push_back(bt);
      end
    end
  end

  // Responder: returns each request in the cycle after its handshake.
  always begin
    logic [AW-1:0] a;
    @(posedge clk);
    #2;
    if (!rst && req_q.size() > 0) begin
      a = req_q.pop_front();
      rd_data = make_beat(a);
      rd_data_valid = 1'b1;
    end else begin
      rd_data_valid = 1'b0;
    end
  end

  task automatic send_task(input logic [VW-1:0] v, input logic [OW-1:0] b,
                           input logic [OW-1:0] e);
    logic acc;
    acc = 1'b0;
    @(posedge clk);
    #1;
    task_vtx_id    = v;
    task_off_begin = b;
    task_off_end   = e;
    task_valid     = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (task_ready) begin
        acc = 1'b1;
        break;
      end
    end
    check_val("task_accept", acc, 1'b1);
    @(posedge clk);
    #1;
    task_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (out_q.size() >= n) break;
      @(negedge clk);
    end
    check_val("beat_count", out_q.size(), n);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (task_ready) break;
    end
    check_val("idle_ready", task_ready, 1'b1);
  endtask

  task automatic clear_logs();
    req_log.delete();
    out_q.delete();
  endtask

  initial begin
    logic any_rd;
    logic any_out;
    logic stable;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_task_ready", task_ready, 1'b1);
    check_val("rst_rd_valid", rd_valid, 1'b0);
    check_val("rst_rd_addr", rd_addr, '0);
    check_val("rst_edge_valid", edge_valid, 1'b0);
    check_val("rst_edge_mask", edge_mask, '0);
    check_val("rst_edge_src", edge_src, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("post_rst_ready", task_ready, 1'b1);

    // Single partial beat: edges 3,4
    send_task(32'd7, 32'd3, 32'd5);
    wait_beats(1, 50);
    check_val("t1_nreq", req_log.size(), 1);
    check_val("t1_addr", req_log[0], 28'd0);
    check_val("t1_src", out_q[0].src, 32'd7);
    check_val("t1_mask", out_q[0].mask, 8'b0001_1000);
    check_val("t1_dst", out_q[0].dst, make_beat(28'd0));
    @(posedge clk);
    #1;
    check_val("t1_ready_back", task_ready, 1'b1);
    clear_logs();

    // Three beats, partial at both ends
    send_task(32'd9, 32'd6, 32'd19);
    wait_beats(3, 60);
    check_val("t2_nreq", req_log.size(), 3);
    check_val("t2_addr0", req_log[0], 28'd0);
    check_val("t2_addr1", req_log[1], 28'd32);
    check_val("t2_addr2", req_log[2], 28'd64);
    check_val("t2_mask0", out_q[0].mask, 8'hC0);
    check_val("t2_mask1", out_q[1].mask, 8'hFF);
    check_val("t2_mask2", out_q[2].mask, 8'h07);
    check_val("t2_dst2", out_q[2].dst, make_beat(28'd64));
    check_val("t2_src", out_q[1].src, 32'd9);
    wait_idle();
    clear_logs();

    // Empty range is dropped
    send_task(32'd2, 32'd10, 32'd10);
    check_val("t3_ready", task_ready, 1'b1);
    any_rd  = 1'b0;
    any_out = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      any_rd  = any_rd | rd_valid;
      any_out = any_out | edge_valid;
    end
    check_val("t3_no_rd", any_rd, 1'b0);
    check_val("t3_no_out", any_out, 1'b0);
    check_val("t3_ready_hold", task_ready, 1'b1);
    clear_logs();

    // Credit limit: 16 beats with the output stalled
    edge_ready = 1'b0;
    send_task(32'd3, 32'd0, 32'd128);
    repeat (30) @(negedge clk);
    check_val("t4_nreq_stall", req_log.size(), 8);
    check_val("t4_rd_valid_stall", rd_valid, 1'b0);
    check_val("t4_edge_valid_stall", edge_valid, 1'b1);
    check_val("t4_no_out_stall", out_q.size(), 0);
    check_val("t4_hold_mask", edge_mask, 8'hFF);
    check_val("t4_hold_dst", edge_dst, make_beat(28'd0));
    @(posedge clk);
    #1;
    edge_ready = 1'b1;
    wait_beats(16, 300);
    check_val("t4_nreq", req_log.size(), 16);
    for (int i = 0; i < 16; i++) begin
      check_val($sformatf("t4_addr%0d", i), req_log[i], 28'(i * 32));
      check_val($sformatf("t4_mask%0d", i), out_q[i].mask, 8'hFF);
      check_val($sformatf("t4_dst%0d", i), out_q[i].dst, make_beat(28'(i * 32)));
    end
    wait_idle();
    clear_logs();

    // Request held while rd_ready is low
    rd_ready = 1'b0;
    send_task(32'd5, 32'd16, 32'd20);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      stable = stable & rd_valid & (rd_addr == 28'd64);
    end
    check_val("t5_stable", stable, 1'b1);
    check_val("t5_no_hs", req_log.size(), 0);
    @(posedge clk);
    #1;
    rd_ready = 1'b1;
    wait_beats(1, 50);
    check_val("t5_nreq", req_log.size(), 1);
    check_val("t5_addr", req_log[0], 28'd64);
    check_val("t5_mask", out_q[0].mask, 8'h0F);
    wait_idle();
    clear_logs();

    // Reset in the middle of a 4-beat task
    rd_ready = 1'b0;
    send_task(32'd4, 32'd16, 32'd48);
    @(posedge clk);
    #1;
    check_val("t6_pre_rd_valid", rd_valid, 1'b1);
    check_val("t6_pre_rd_addr", rd_addr, 28'd64);
    check_val("t6_pre_ready", task_ready, 1'b0);
    rst = 1'b1;
    req_q.delete();
    @(posedge clk);
    #1;
    check_val("t6_rst_ready", task_ready, 1'b1);
    check_val("t6_rst_rd_valid", rd_valid, 1'b0);
    check_val("t6_rst_rd_addr", rd_addr, '0);
    check_val("t6_rst_edge_valid", edge_valid, 1'b0);
    check_val("t6_rst_edge_mask", edge_mask, '0);
    rst = 1'b0;
    rd_ready = 1'b1;
    clear_logs();
    send_task(32'd11, 32'd8, 32'd9);
    wait_beats(1, 50);
    check_val("t6_nreq", req_log.size(), 1);
    check_val("t6_addr", req_log[0], 28'd32);
    check_val("t6_mask", out_q[0].mask, 8'h01);
    check_val("t6_src", out_q[0].src, 32'd11);
    check_val("t6_dst", out_q[0].dst, make_beat(28'd32));
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
